serial_subtractor: RTL and testbench

- Bit-serial unsigned subtractor: accepts operands A and B through a valid/ready handshake and computes the difference LSB-first, one bit per clock.
- The per-bit cell is a full subtractor (half-subtractor pair plus a borrow flip-flop).
- Presents `(A - B) mod 2^WIDTH` and the final borrow on a valid/ready output handshake.
- Area-cheap arithmetic unit alongside the team's combinational adder cells; its result is checked against the same XOR/AND-style bit equations.

---
 rtl/serial_subtractor_if.sv | 13 +
 rtl/serial_subtractor.sv | 54 +++++
 tb/tb_serial_subtractor.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/serial_subtractor_if.sv
// serial_subtractor_if: operand/result valid-ready bundle for the bit-serial subtractor.
interface serial_subtractor_if #(parameter int WIDTH = 8);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             borrow;
    modport master (output in_valid, a, b, out_ready, input in_ready, out_valid, diff, borrow);
    modport slave  (input in_valid, a, b, out_ready, output in_ready, out_valid, diff, borrow);
endinterface

// File: rtl/serial_subtractor.sv
// serial_subtractor: LSB-first bit-serial unsigned subtractor, one full-subtractor step per clock.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input logic          clk,
    input logic          rst_n,
    serial_subtractor_if.slave s
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    state_t state, nxt;
    logic [WIDTH-1:0] a_sh, b_sh, res;
    logic [CW-1:0] cnt;
    logic br, x, y, d, br_nxt;
    assign x = a_sh[0];
    assign y = b_sh[0];
    assign d = x ^ y ^ br;
    assign br_nxt = (~x & y) | (~(x ^ y) & br);
    assign s.diff = res;
    assign s.borrow = br;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else state <= nxt;
    end
    always_comb begin
        nxt = state == IDLE  ? (s.in_valid ? SHIFT : IDLE) :
              state == SHIFT ? (cnt == LAST ? DONE : SHIFT) :
                               (s.out_ready ? IDLE : DONE);
        s.in_ready = state == IDLE;
        s.out_valid = state == DONE;
    end
    // Each difference bit enters at the MSB so the LSB lands at bit 0 after WIDTH shifts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh <= '0;
            b_sh <= '0;
            res <= '0;
            cnt <= '0;
            br <= 1'b0;
        end else if (state == IDLE && s.in_valid) begin
            a_sh <= s.a;
            b_sh <= s.b;
            cnt <= '0;
            br <= 1'b0;
        end else if (state == SHIFT) begin
            a_sh <= a_sh >> 1;
            b_sh <= b_sh >> 1;
            res <= WIDTH'({d, res} >> 1);
            cnt <= cnt + CW'(1);
            br <= br_nxt;
        end
    end
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed vectors against a latency/arithmetic reference model for WIDTH 8 and 1.
module tb_serial_subtractor;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int total = 0;
    int bad = 0;
    int cyc = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    serial_subtractor_if #(.WIDTH(8)) m8();
    serial_subtractor_if #(.WIDTH(1)) m1();
    serial_subtractor #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .s(m8));
    serial_subtractor #(.WIDTH(1)) dut1 (.clk(clk), .rst_n(rst_n), .s(m1));

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        int         acc;
    } rec_t;
    rec_t q[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Reference: an accepted pair is busy for exactly 8 cycles, then presents a-b mod 256 and a<b until taken.
    always @(negedge clk) begin
        logic exp_ov;
        if (!rst_n) begin
            q.delete();
            chk("m_rst_in_ready", m8.in_ready, 1);
            chk("m_rst_out_valid", m8.out_valid, 0);
            chk("m_rst_diff", m8.diff, 0);
            chk("m_rst_borrow", m8.borrow, 0);
        end else begin
            exp_ov = q.size() > 0 && (cyc - q[0].acc >= 8);
            chk("m_in_ready", m8.in_ready, q.size() == 0);
            chk("m_out_valid", m8.out_valid, exp_ov);
            if (exp_ov) begin
                chk("m_diff", m8.diff, 8'(q[0].a - q[0].b));
                chk("m_borrow", m8.borrow, q[0].a < q[0].b);
                if (m8.out_ready) void'(q.pop_front());
            end else if (q.size() == 0 && m8.in_valid) begin
                q.push_back('{a: m8.a, b: m8.b, acc: cyc + 1});
            end
        end
    end

    task automatic xact8(input logic [7:0] av, input logic [7:0] bv, input logic [7:0] ed, input logic eb, input int hold);
        int n;
        @(posedge clk); #1;
        m8.a = av;
        m8.b = bv;
        m8.in_valid = 1'b1;
        m8.out_ready = 1'b0;
        @(posedge clk); #1;
        m8.in_valid = 1'b0;
        m8.a = ~av;
        m8.b = ~bv;
        chk("busy_in_ready", m8.in_ready, 0);
        n = 0;
        while (!m8.out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("latency", n, 8);
        chk("diff", m8.diff, ed);
        chk("borrow", m8.borrow, eb);
        for (int i = 0; i < hold; i++) begin
            m8.in_valid = 1'b1;
            m8.a = 8'h11;
            m8.b = 8'h11;
            @(posedge clk); #1;
            chk("bp_out_valid", m8.out_valid, 1);
            chk("bp_in_ready", m8.in_ready, 0);
            chk("bp_diff", m8.diff, ed);
            chk("bp_borrow", m8.borrow, eb);
        end
        m8.in_valid = 1'b0;
        m8.out_ready = 1'b1;
        @(posedge clk); #1;
        m8.out_ready = 1'b0;
        chk("post_out_valid", m8.out_valid, 0);
        chk("post_in_ready", m8.in_ready, 1);
    endtask

    task automatic xact1(input logic av, input logic bv, input logic ed, input logic eb);
        @(posedge clk); #1;
        m1.a = av;
        m1.b = bv;
        m1.in_valid = 1'b1;
        m1.out_ready = 1'b1;
        @(posedge clk); #1;
        m1.in_valid = 1'b0;
        chk("w1_shift_out_valid", m1.out_valid, 0);
        @(posedge clk); #1;
        chk("w1_out_valid", m1.out_valid, 1);
        chk("w1_diff", m1.diff, ed);
        chk("w1_borrow", m1.borrow, eb);
        @(posedge clk); #1;
        chk("w1_idle_out_valid", m1.out_valid, 0);
        chk("w1_idle_in_ready", m1.in_ready, 1);
    endtask

    initial begin
        m8.in_valid = 1'b0;
        m8.a = '0;
        m8.b = '0;
        m8.out_ready = 1'b0;
        m1.in_valid = 1'b0;
        m1.a = '0;
        m1.b = '0;
        m1.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", m8.in_ready, 1);
        chk("rst_out_valid", m8.out_valid, 0);
        chk("rst_diff", m8.diff, 8'h00);
        chk("rst_borrow", m8.borrow, 0);
        chk("w1_rst_in_ready", m1.in_ready, 1);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        chk("idle_after_rst", m8.in_ready, 1);
        xact8(8'h5A, 8'h21, 8'h39, 1'b0, 0);
        xact8(8'h03, 8'h05, 8'hFE, 1'b1, 0);
        xact8(8'hFF, 8'hFF, 8'h00, 1'b0, 0);
        xact8(8'h00, 8'hFF, 8'h01, 1'b1, 0);
        xact8(8'h80, 8'h01, 8'h7F, 1'b0, 5);
        @(posedge clk); #1;
        m8.a = 8'h10;
        m8.b = 8'h20;
        m8.in_valid = 1'b1;
        @(posedge clk); #1;
        m8.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_in_ready", m8.in_ready, 1);
        chk("abort_out_valid", m8.out_valid, 0);
        chk("abort_diff", m8.diff, 8'h00);
        chk("abort_borrow", m8.borrow, 0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            chk("abort_no_out_valid", m8.out_valid, 0);
        end
        xact8(8'h10, 8'h20, 8'hF0, 1'b1, 0);
        xact1(1'b0, 1'b0, 1'b0, 1'b0);
        xact1(1'b1, 1'b0, 1'b1, 1'b0);
        xact1(1'b0, 1'b1, 1'b1, 1'b1);
        xact1(1'b1, 1'b1, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
